// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data-memory
// responder (slave). Both directions use a valid/ready handshake.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: one request at a time, IDLE -> WAIT -> RESP.
// Holds the word array and registered shadows of two result words.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int OUT1_IDX    = 0,
    parameter int OUT2_IDX    = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output logic [31:0]       out1,
    output logic [31:0]       out2
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] out1_q, out1_d;
    logic [31:0] out2_q, out2_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] old_q;
    logic [31:0] merged;
    logic        accept;
    logic        commit;
    logic        addr_err;
    logic        mem_we;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid;
    assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    // Gated by rst so an edge racing the reset assertion cannot write.
    assign mem_we   = commit && wr_q && !addr_err && rst;

    // The old word is read at accept time, so it is ready even when LATENCY=1.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : old_q[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q[AW+1:2]] <= merged;
        end
        if (accept) begin
            old_q <= mem[bus.req_addr[AW+1:2]];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (addr_err) begin
                        err_d = 1'b1;
                    end else if (wr_q) begin
                        if (addr_q[31:2] == 30'(OUT1_IDX)) out1_d = merged;
                        if (addr_q[31:2] == 30'(OUT2_IDX)) out2_d = merged;
                    end else begin
                        rdata_d = old_q;
                    end
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            out1_q  <= 32'd0;
            out2_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign out1           = out1_q;
    assign out2           = out2_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, corner-case sequences and
// random traffic checked against a word-array reference model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;
    logic [31:0] out1;
    logic [31:0] out2;
    int          errors = 0;
    int          checks = 0;
    int          txn_no = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .OUT1_IDX   (0),
        .OUT2_IDX   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .out1(out1),
        .out2(out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic garbage_req();
        bus.req_valid = 1'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er);
        int k;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_be     = be;
        bus.resp_ready = 1'b0;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        garbage_req();
        k = 0;
        rd = 32'd0;
        er = 1'b0;
        forever begin
            @(negedge clk);
            k++;
            if (bus.resp_valid) break;
            chk("req_ready_wait", 32'(bus.req_ready), 32'd0);
            if (k > 40) begin
                chk("resp_timeout", 32'(k), 32'(LAT + 1));
                bus.req_valid = 1'b0;
                return;
            end
            garbage_req();
        end
        chk("latency", 32'(k), 32'(LAT + 1));
        rd = bus.resp_rdata;
        er = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            garbage_req();
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_rdata", bus.resp_rdata, rd);
            chk("hold_err", 32'(bus.resp_err), 32'(er));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(bus.resp_valid), 32'd0);
        chk("post_rdata", bus.resp_rdata, 32'd0);
        chk("post_err", 32'(bus.resp_err), 32'd0);
        chk("post_req_ready", 32'(bus.req_ready), 32'd1);
        txn_no++;
        $display("txn %0d wr=%0b addr=%h wdata=%h be=%h hold=%0d -> rdata=%h err=%0b out1=%h out2=%h",
                 txn_no, wr, addr, wd, be, hold, rd, er, out1, out2);
    endtask

    // Reference model: plain word array covering words 0..15 plus the two shadows.
    logic [31:0] m [16];
    logic [31:0] sh1;
    logic [31:0] sh2;

    task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, output logic [31:0] rd, output logic er);
        int w;
        w  = int'(addr >> 2);
        er = (addr % 4 != 0) || ((addr >> 2) >= 32'(DEPTH));
        rd = 32'd0;
        if (!er) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m[w][8*b +: 8] = wd[8*b +: 8];
                if (w == 0) sh1 = m[w];
                if (w == 1) sh2 = m[w];
            end else begin
                rd = m[w];
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_o1;
        logic [31:0] exp_o2;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] erd;
        logic        eer;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  be;

        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 32'h0,    32'h11223344, 4'hF, 32'h0,        1'b0, 32'h11223344, 32'h0};
        tbl[3]  = '{1'b1, 32'h0,    32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 32'h11BB33DD, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h11BB33DD, 1'b0, 32'h11BB33DD, 32'h0};
        tbl[5]  = '{1'b0, 32'h6,    32'h0,        4'h0, 32'h0,        1'b1, 32'h11BB33DD, 32'h0};
        tbl[6]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 32'h11BB33DD, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h11BB33DD, 1'b0, 32'h11BB33DD, 32'h0};
        tbl[8]  = '{1'b1, 32'h4,    32'h01020304, 4'hF, 32'h0,        1'b0, 32'h11BB33DD, 32'h01020304};
        tbl[9]  = '{1'b1, 32'h4,    32'h55667788, 4'h0, 32'h0,        1'b0, 32'h11BB33DD, 32'h01020304};
        tbl[10] = '{1'b0, 32'h4,    32'h0,        4'h0, 32'h01020304, 1'b0, 32'h11BB33DD, 32'h01020304};
        tbl[11] = '{1'b1, 32'h20,   32'h12345678, 4'hF, 32'h0,        1'b0, 32'h11BB33DD, 32'h01020304};
        tbl[12] = '{1'b1, 32'h2,    32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 32'h11BB33DD, 32'h01020304};
        tbl[13] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h11BB33DD, 1'b0, 32'h11BB33DD, 32'h01020304};

        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_be     = 4'd0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("init_req_ready", 32'(bus.req_ready), 32'd1);
        chk("init_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("init_rdata", bus.resp_rdata, 32'd0);
        chk("init_err", 32'(bus.resp_err), 32'd0);
        chk("init_out1", out1, 32'd0);
        chk("init_out2", out2, 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, i % 3, rd, er);
            chk("tbl_rdata", rd, tbl[i].exp_rd);
            chk("tbl_err", 32'(er), 32'(tbl[i].exp_err));
            chk("tbl_out1", out1, tbl[i].exp_o1);
            chk("tbl_out2", out2, tbl[i].exp_o2);
        end

        // Back-pressure for 4 cycles, then a request right after the bubble.
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 4, rd, er);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        chk("bp_err", 32'(er), 32'd0);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("bp_next_rdata", rd, 32'h12345678);

        // Reset during WAIT drops the store.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out1", out1, 32'd0);
        chk("midrst_out2", out2, 32'd0);
        chk("midrst_valid_after", 32'(bus.resp_valid), 32'd0);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1, rd, er);
        chk("midrst_load", rd, 32'h12345678);

        // Random traffic against the model, starting from fully-written words 0..15.
        sh1 = 32'd0;
        sh2 = 32'd0;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            a = 32'(i * 4);
            model_apply(1'b1, a, d, 4'hF, erd, eer);
            do_txn(1'b1, a, d, 4'hF, 0, rd, er);
            chk("init_store_err", 32'(er), 32'(eer));
        end
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1: a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            w  = 1'($urandom);
            d  = $urandom;
            be = 4'($urandom);
            model_apply(w, a, d, be, erd, eer);
            do_txn(w, a, d, be, $urandom_range(0, 3), rd, er);
            chk("rnd_rdata", rd, erd);
            chk("rnd_err", 32'(er), 32'(eer));
            chk("rnd_out1", out1, sh1);
            chk("rnd_out2", out2, sh2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving load/store requests from the pipeline MEM stage over a valid/ready request channel and a valid/ready response channel. Access latency is configurable, so the pipeline exercises its stall path against a non-zero-latency memory. Holds the data array. Exports two memory-mapped result words (out1/out2) as registered shadows for the top-level observation ports.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
LATENCY, 2, number of WAIT cycles between request accept and commit; legal range 1..15
OUT1_IDX, 0, word index mirrored on out1
OUT2_IDX, 1, word index mirrored on out2

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  store byte enables; bit i covers bits [8i+7:8i]
resp_valid  out  1  response present
resp_ready  in  1  requester accepts the response
resp_rdata  out  32  load data; 0 for stores and errors
resp_err  out  1  misaligned or out-of-range access
out1  out  32  shadow of word OUT1_IDX
out2  out  32  shadow of word OUT2_IDX

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, out1=0, out2=0, counter=0.
  - The memory array is not cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata/be, load counter with LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. If counter!=0, decrement. If counter==0, commit the access and go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid&resp_ready; then go to IDLE and clear resp_valid, resp_rdata and resp_err.
- Timing: request accepted in cycle N; first cycle with resp_valid=1 is N+LATENCY+1.
- req_ready is 0 in WAIT and RESP. Requests presented there are ignored, not queued. After a handshake in RESP, the next request is accepted no earlier than the following cycle (one-cycle bubble).
- Error check at commit: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - err=1: no array write, resp_rdata=0, resp_err=1.
- Load commit: resp_rdata = mem[addr[31:2]], resp_err=0.
- Store commit:
  - Each byte with be[i]=1 is written; other bytes are preserved.
  - be=0 is a legal no-op that still gets a response.
  - resp_rdata=0, resp_err=0.
- Shadows: on a store commit to OUT1_IDX or OUT2_IDX, the matching shadow is updated with the same merged word written to the array, in the same clock edge.
- Reset mid-operation: a transaction in WAIT before commit is dropped with no array write and no response. A transaction in RESP is dropped; the array keeps its committed value.
- Latched request fields do not change while in WAIT or RESP, whatever req_* does.
- Counter width is 4 bits. Counter wrap is impossible within the legal LATENCY range.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, out1=out2=0.
- Store then load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, accepted cycle N -> resp_valid high at N+3, resp_err=0.
  - Then load 0x10 -> resp_rdata=0xDEADBEEF, 3 cycles after its accept.
- Partial store and shadow:
  - Store word OUT1_IDX (addr 0x0) with 0x11223344, be=F, then store 0xAABBCCDD, be=4'b0101 -> out1=0x11BB33DD.
  - Then load 0x0 -> resp_rdata=0x11BB33DD.
- Errors:
  - Load addr=0x6 -> resp_err=1, resp_rdata=0.
  - Store addr=DEPTH_WORDS*4 -> resp_err=1, and a following load of word 0 is unchanged.
- Back-pressure:
  - resp_ready=0 for 4 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0, and a new req_valid is not accepted.
  - Then resp_ready=1 -> IDLE next cycle, next request accepted the cycle after.
- Reset mid-WAIT: store 0xCAFEF00D to 0x20, assert rst during WAIT -> no response; after release, load 0x20 returns the prior value.
